// File: rtl/conv_encoder_framer_if.sv
// Bit-stream handshake bundle for conv_encoder_framer: the input bit channel and the
// output code-symbol channel. The slave modport is the encoder side.
interface conv_encoder_framer_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic       out_last;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_sym, out_last
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_sym, out_last
  );
endinterface

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 K=5 convolutional encoder with fixed-length framing and 4-bit zero tail.
// Optional frame counter output enabled by defining CONV_ENC_FRAME_CNT_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for the first information bit of a frame
// DATA  | accepting and encoding information bits 2..FRAME_LEN
// TAIL  | flushing four zero bits so the trellis ends in state 0
module conv_encoder_framer #(
  parameter int         FRAME_LEN = 64,
  parameter logic [4:0] G0        = 5'b10011,
  parameter logic [4:0] G1        = 5'b11101
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  conv_encoder_framer_if.slave  bus,
  output logic                  busy
`ifdef CONV_ENC_FRAME_CNT_EN
  ,
  output logic [15:0]           frames_done
`endif
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  localparam logic [15:0] LAST_BIT = 16'(FRAME_LEN);

  state_t      state, state_nxt;
  logic [3:0]  sr, sr_nxt;
  logic [15:0] bit_cnt, bit_cnt_nxt;
  logic [1:0]  tail_cnt, tail_cnt_nxt;

  logic        out_valid_q, out_last_q;
  logic [1:0]  out_sym_q;

  logic        reg_free, adv, in_ready_int, accept, produce, last_nxt;
  logic        u, p0, p1;
  logic [4:0]  vec;

  // A pop in the same cycle frees the single-entry output register.
  assign reg_free     = !out_valid_q || bus.out_ready;
  assign adv          = enable && reg_free;
  assign in_ready_int = rst && adv && ((state == IDLE) || (state == DATA));
  assign accept       = bus.in_valid && in_ready_int;

  assign u   = (state == TAIL) ? 1'b0 : bus.in_bit;
  assign vec = {u, sr};
  assign p0  = ^(vec & G0);
  assign p1  = ^(vec & G1);

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    tail_cnt_nxt = tail_cnt;
    produce      = 1'b0;
    last_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          produce     = 1'b1;
          bit_cnt_nxt = 16'd1;
          state_nxt   = (LAST_BIT == 16'd1) ? TAIL : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          produce     = 1'b1;
          bit_cnt_nxt = bit_cnt + 16'd1;
          if (bit_cnt + 16'd1 == LAST_BIT) state_nxt = TAIL;
        end
      end
      TAIL: begin
        if (adv) begin
          produce = 1'b1;
          if (tail_cnt == 2'd3) begin
            last_nxt     = 1'b1;
            tail_cnt_nxt = 2'd0;
            bit_cnt_nxt  = 16'd0;
            state_nxt    = IDLE;
          end else begin
            tail_cnt_nxt = tail_cnt + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    sr_nxt = produce ? {u, sr[3:1]} : sr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sr          <= 4'd0;
      bit_cnt     <= 16'd0;
      tail_cnt    <= 2'd0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 2'd0;
      out_last_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tail_cnt <= tail_cnt_nxt;
      if (produce) begin
        out_valid_q <= 1'b1;
        out_sym_q   <= {p0, p1};
        out_last_q  <= last_nxt;
      end else if (enable && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

`ifdef CONV_ENC_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frames_done <= 16'd0;
    end else if (enable && out_valid_q && bus.out_ready && out_last_q &&
                 (frames_done != 16'hFFFF)) begin
      frames_done <= frames_done + 16'd1;
    end
  end
`endif

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sym   = out_sym_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state == DATA) || (state == TAIL);

endmodule

// File: doc/conv_encoder_framer.md
Name: conv_encoder_framer

Overview:
- Rate-1/2, K=5 (16-state) convolutional encoder feeding the Viterbi decoder datapath.
- Accepts a bit stream in fixed-length frames with a valid/ready handshake.
- Emits one 2-bit code symbol per information bit, then appends K-1 zero tail bits so every frame ends in state 0. The decoder's traceback therefore always starts from state 0.
- Sits at the transmit end of the codec and is the source for decoder testbenches and the on-chip loopback.

Parameters:
- FRAME_LEN, 64, information bits per frame; legal range 1..65535.
- G0, 5'b10011 (octal 23), generator polynomial for out_sym[1]; bit 4 applies to the current input bit.
- G1, 5'b11101 (octal 35), generator polynomial for out_sym[0]; same bit ordering as G0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low; asserted when 0.
- enable  in  1  global advance enable; when low the block freezes.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  block accepts in_bit this cycle.
- in_bit  in  1  information bit.
- out_valid  out  1  out_sym is valid.
- out_ready  in  1  downstream accepts out_sym this cycle.
- out_sym  out  2  code symbol {p0,p1}; its value 0..3 is the branch-metric index.
- out_last  out  1  marks the final tail symbol of the frame.
- busy  out  1  frame in progress (state is DATA or TAIL).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register sr[3:0]=0, bit count=0, tail count=0. Outputs: out_valid=0, out_sym=0, out_last=0, busy=0, in_ready=0 while in reset.
- Encoding, for input bit u:
  - vec={u,sr[3:0]}.
  - p0=^(vec&G0), p1=^(vec&G1).
  - Next sr={u,sr[3:1]}.
- Output register is single-entry. It is free when out_valid=0 or out_ready=1 (a pop in the same cycle counts as free).
- Advance condition: adv = enable & reg_free.
- State machine:
  - IDLE: in_ready=adv. On in_valid&in_ready, encode in_bit and go to DATA (or TAIL if FRAME_LEN=1); bit count=1.
  - DATA: in_ready=adv. On each accepted bit, encode it and increment the bit count. When the count reaches FRAME_LEN, go to TAIL.
  - TAIL: in_ready=0. While adv, encode u=0 each cycle and increment the tail count. On the 4th tail symbol, set out_last=1 and return to IDLE.
- Latency: an accepted bit appears on out_sym the next cycle. Symbols per frame = FRAME_LEN+4.
- Holding rule: out_valid=1 with out_ready=0 holds out_sym and out_last stable until accepted.
- Register update:
  - If a symbol is produced, out_valid=1 with the new out_sym/out_last.
  - Else if out_ready=1, out_valid=0.
- In_valid gaps: in IDLE/DATA with no input, no symbol is produced and the register drains normally.
- enable=0:
  - No state, counter, sr or output-register change (out_valid is held even if out_ready=1).
  - in_ready=0.
- Back-to-back frames: from IDLE, the first bit of the next frame may be accepted in the cycle after out_last is loaded, subject to the free-register rule. sr is 0 at frame start by construction.
- busy=1 in DATA and TAIL, and deasserts when returning to IDLE.
- Reset mid-frame: frame is abandoned immediately, all state cleared, no out_last is emitted.

Optional Feature:
- Macro: CONV_ENC_FRAME_CNT_EN.
- Defined:
  - Adds output port frames_done [15:0], reset to 0.
  - Increments when an out_last symbol is accepted (out_valid&out_ready&out_last).
  - Saturates at 16'hFFFF and is frozen by enable=0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Impulse: FRAME_LEN=1, in_bit=1, out_ready=1 -> out_sym 3,1,1,2,3 on 5 consecutive cycles, out_last only on the 5th, then busy=0.
- All-zero frame: FRAME_LEN=64, 64 zeros -> 68 symbols all 0, out_last on symbol 68, in_ready=0 for the 4 tail cycles.
- Backpressure: impulse frame with out_ready=0 for 3 cycles after the first symbol -> out_sym holds 3, in_ready=0, no symbol lost or duplicated; sequence remains 3,1,1,2,3.
- enable low: deassert enable for 5 cycles mid-DATA with out_ready=1 -> outputs, in_ready=0 and counters frozen. After re-enable, the frame completes with the correct 68 symbols, matching a reference model of the (23,35) encoder.
- Reset mid-frame: assert rst low asynchronously after 10 bits -> out_valid=0 and busy=0 immediately. A new impulse frame after release yields 3,1,1,2,3 (sr cleared).
- CONV_ENC_FRAME_CNT_EN: 3 back-to-back FRAME_LEN=1 frames -> frames_done=3; with the macro undefined, the block compiles without the port.
